axi_mem_responder: RTL

- AXI4 subordinate (responder) backing memory that serves the burst read and write traffic issued by the instruction and data caches.
- Sits at the far end of the cache AXI buses in the simulation/FPGA top.
- Handles exactly one transaction at a time.
- Optionally emits an AC snoop invalidate after each completed write, so data-cache coherence logic gets exercised.

---
 rtl/axi_pkg.sv | 20 ++
 rtl/axi_mem_responder_if.sv | 73 +++++++
 rtl/axi_mem_array.sv | 28 ++
 rtl/axi_mem_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings and the responder state type used by axi_mem_responder
// and its bench.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B     = 3'b011;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [3:0] AC_MAKE_INVALID = 4'hD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_BURST,
    ST_WR_DATA,
    ST_WR_SNOOP,
    ST_WR_RESP
  } axi_mem_state_t;

endpackage

// File: rtl/axi_mem_responder_if.sv
// AXI4 read/write channels plus the AC snoop channel between a cache master and
// the backing-memory responder.
interface axi_mem_responder_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  // Every channel transfers on the rising edge where valid && ready; a source
  // keeps valid and its payload stable until that edge, ready may change freely.
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;

  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rlast;

  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;

  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;

  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;

  logic                    acvalid;
  logic                    acready;
  logic [ADDR_WIDTH-1:0]   acaddr;
  logic [3:0]              acsnoop;

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rlast,
    input  rready,
    input  awvalid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp,
    input  bready,
    output acvalid, acaddr, acsnoop,
    input  acready
  );

  modport master (
    output arvalid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rlast,
    output rready,
    output awvalid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp,
    output bready,
    input  acvalid, acaddr, acsnoop,
    output acready
  );

endinterface

// File: rtl/axi_mem_array.sv
// Byte-strobed 64-bit register array: one synchronous write port, one
// asynchronous read port.
module axi_mem_array #(
  parameter int WORDS = 4096,
  parameter int IDX_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [63:0]      wdata,
  input  logic [7:0]       wstrb,
  input  logic [IDX_W-1:0] raddr,
  output logic [63:0]      rdata
);

  logic [63:0] mem [WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (we && wstrb[i]) begin
        mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 backing-memory responder, one transaction at a time.
// Define AXI_MEM_SNOOP_EN to emit an AC MakeInvalid snoop after each write.
module axi_mem_responder
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int MEM_WORDS    = 4096,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  axi_mem_responder_if.slave    s_axi,
  output axi_mem_state_t        dbg_state
);

  localparam int         IDX_W    = $clog2(MEM_WORDS);
  localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);

  axi_mem_state_t   state;
  logic [IDX_W-1:0] idx;
  // cnt holds beats remaining on reads and beats accepted on writes
  logic [8:0]       beats;
  logic [8:0]       cnt;
  logic [3:0]       lat;

  logic             rvalid_q;
  logic             rlast_q;
  logic [63:0]      rdata_q;
  logic             bvalid_q;
  logic [1:0]       bresp_q;

  logic             ar_hs, aw_hs, r_hs, w_hs, b_hs;
  logic             wr_full, wr_err, mem_we;
  logic [IDX_W-1:0] idx_next, rd_idx;
  logic [63:0]      rd_word;

  assign s_axi.arready = !reset && (state == ST_IDLE);
  assign s_axi.awready = !reset && (state == ST_IDLE) && !s_axi.arvalid;
  assign s_axi.wready  = !reset && (state == ST_WR_DATA);
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign dbg_state     = state;

  assign ar_hs = s_axi.arvalid && s_axi.arready;
  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign r_hs  = rvalid_q && s_axi.rready;
  assign w_hs  = s_axi.wvalid && s_axi.wready;
  assign b_hs  = bvalid_q && s_axi.bready;

  // Index wraps naturally because MEM_WORDS is a power of two.
  assign idx_next = idx + 1'b1;
  assign rd_idx   = (state == ST_RD_BURST) ? idx_next : idx;
  // Beats past the declared length are accepted but never reach the array.
  assign wr_full  = (cnt == beats);
  assign wr_err   = wr_full || ((cnt + 9'd1) != beats);
  assign mem_we   = w_hs && !wr_full;

  // Size and burst type are not decoded: every burst is 64-bit INCR.
  logic unused_bits;
  assign unused_bits = ^{s_axi.araddr, s_axi.awaddr, s_axi.arsize, s_axi.arburst,
                         s_axi.awsize, s_axi.awburst};

  axi_mem_array #(
    .WORDS (MEM_WORDS),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (idx),
    .wdata (s_axi.wdata),
    .wstrb (s_axi.wstrb),
    .raddr (rd_idx),
    .rdata (rd_word)
  );

`ifdef AXI_MEM_SNOOP_EN
  logic                  acvalid_q;
  logic [ADDR_WIDTH-1:0] acaddr_q;
  logic [3:0]            acsnoop_q;
  logic [ADDR_WIDTH-1:0] aw_addr;

  assign s_axi.acvalid = acvalid_q;
  assign s_axi.acaddr  = acaddr_q;
  assign s_axi.acsnoop = acsnoop_q;
`else
  assign s_axi.acvalid = 1'b0;
  assign s_axi.acaddr  = '0;
  assign s_axi.acsnoop = 4'h0;

  logic unused_ac;
  assign unused_ac = s_axi.acready;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      beats    <= '0;
      cnt      <= '0;
      lat      <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdata_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= AXI_RESP_OKAY;
`ifdef AXI_MEM_SNOOP_EN
      acvalid_q <= 1'b0;
      acaddr_q  <= '0;
      acsnoop_q <= 4'h0;
      aw_addr   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (ar_hs) begin
            idx   <= s_axi.araddr[3 +: IDX_W];
            cnt   <= 9'(s_axi.arlen) + 9'd1;
            lat   <= LAT_INIT;
            state <= ST_RD_WAIT;
          end else if (aw_hs) begin
            idx   <= s_axi.awaddr[3 +: IDX_W];
            beats <= 9'(s_axi.awlen) + 9'd1;
            cnt   <= '0;
            state <= ST_WR_DATA;
`ifdef AXI_MEM_SNOOP_EN
            aw_addr <= s_axi.awaddr;
`endif
          end
        end

        ST_RD_WAIT: begin
          if (lat == 4'd0) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_word;
            rlast_q  <= (cnt == 9'd1);
            state    <= ST_RD_BURST;
          end else begin
            lat <= lat - 4'd1;
          end
        end

        ST_RD_BURST: begin
          if (r_hs) begin
            if (rlast_q) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              idx     <= idx_next;
              cnt     <= cnt - 9'd1;
              rdata_q <= rd_word;
              rlast_q <= (cnt == 9'd2);
            end
          end
        end

        ST_WR_DATA: begin
          if (w_hs) begin
            if (!wr_full) begin
              idx <= idx_next;
              cnt <= cnt + 9'd1;
            end
            if (s_axi.wlast) begin
              bresp_q <= wr_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
`ifdef AXI_MEM_SNOOP_EN
              acvalid_q <= 1'b1;
              acaddr_q  <= aw_addr & ~ADDR_WIDTH'(63);
              acsnoop_q <= AC_MAKE_INVALID;
              state     <= ST_WR_SNOOP;
`else
              bvalid_q  <= 1'b1;
              state     <= ST_WR_RESP;
`endif
            end
          end
        end

        ST_WR_SNOOP: begin
`ifdef AXI_MEM_SNOOP_EN
          if (acvalid_q && s_axi.acready) begin
            acvalid_q <= 1'b0;
            acaddr_q  <= '0;
            acsnoop_q <= 4'h0;
            bvalid_q  <= 1'b1;
            state     <= ST_WR_RESP;
          end
`else
          state <= ST_IDLE;
`endif
        end

        ST_WR_RESP: begin
          if (b_hs) begin
            bvalid_q <= 1'b0;
            bresp_q  <= AXI_RESP_OKAY;
            state    <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
